// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, 8-bit MSB-first frames, one-deep
// transmit holding register with req/ack, received-byte strobe.
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       SPI_SCLK,
    input  logic       SPI_CS,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic       tx_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic [SYNC_STAGES:0]   fill;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t      state, state_n;
    logic [3:0]  bit_cnt;
    logic [7:0]  tx_shift, rx_shift, hold;
    logic        miso;

    // CS chain resets high so busy/MISO come out of reset idle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    // fill qualifies the fall so a CS held low across reset release is not a frame start
    assign cs_fall   = ~cs_s & cs_d & fill[SYNC_STAGES];

    assign busy     = ~cs_s;
    assign SPI_MISO = miso & ~cs_s;
    assign tx_ack   = tx_req & ~tx_full;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (cs_rise) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_n = LOAD;
                LOAD:    state_n = SHIFT;
                SHIFT:   if (sclk_fall && bit_cnt == 4'd8) state_n = LOAD;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold        <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (tx_ack) begin
                hold    <= tx_data;
                tx_full <= 1'b1;
            end
            if (cs_rise || state == IDLE) begin
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else if (state == LOAD) begin
                if (tx_full) begin
                    tx_shift <= hold;
                    miso     <= hold[7];
                    tx_full  <= 1'b0;
                end else begin
                    tx_shift    <= IDLE_BYTE;
                    miso        <= IDLE_BYTE[7];
                    tx_underrun <= 1'b1;
                end
            end else if (sclk_rise && bit_cnt < 4'd8) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                    rx_data  <= {rx_shift[6:0], mosi_s};
                    rx_valid <= 1'b1;
                end
            end else if (sclk_fall) begin
                if (bit_cnt == 4'd8) begin
                    bit_cnt <= '0;
                end else if (bit_cnt != 4'd0) begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    miso     <= tx_shift[6];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master feeds a scoreboard of
// expected received bytes and expected MISO bytes, checked by a separate monitor.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       SPI_SCLK = 1'b0;
    logic       SPI_CS = 1'b1;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ack, tx_full, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int under_cnt = 0;
    int u0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] obs_miso[$];

    spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
        .clk(clk), .nrst(nrst), .SPI_SCLK(SPI_SCLK), .SPI_CS(SPI_CS),
        .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .tx_req(tx_req),
        .tx_data(tx_data), .tx_ack(tx_ack), .tx_full(tx_full),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] a, e;
        if (tx_underrun) under_cnt++;
        if (rx_valid) begin
            if (exp_rx.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data);
            end else begin
                e = exp_rx.pop_front();
                chk("rx_data", rx_data, e);
            end
        end
        while (obs_miso.size() > 0) begin
            a = obs_miso.pop_front();
            if (exp_miso.size() == 0) begin
                checks++; errors++;
                $display("FAIL miso_unexpected: got %0h expected none", a);
            end else begin
                e = exp_miso.pop_front();
                chk("miso_byte", a, e);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_put(input logic [7:0] d);
        bit got = 1'b0;
        bit bad = 1'b0;
        @(negedge clk);
        tx_req  = 1'b1;
        tx_data = d;
        for (int i = 0; i < 400 && !got; i++) begin
            #1;
            if (tx_ack && tx_full) bad = 1'b1;
            if (tx_ack) got = 1'b1;
            else @(negedge clk);
        end
        chk("tx_ack_seen", got, 1);
        chk("ack_while_full", bad, 0);
        if (got) begin
            @(negedge clk);
            #1;
            chk("tx_ack_pulse_full", {tx_ack, tx_full}, 2'b01);
        end
        tx_req = 1'b0;
    endtask

    task automatic cs_low();
        SPI_CS = 1'b0;
        wait_n(8);
    endtask

    // one byte (or a partial one); last raises CS together with the final SCLK fall
    task automatic xfer(input logic [7:0] b, input int nbits, input bit last);
        logic [7:0] got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = b[7-i];
            wait_n(8);
            got[7-i] = SPI_MISO;
            SPI_SCLK = 1'b1;
            wait_n(8);
            if (last && i == nbits - 1) SPI_CS = 1'b1;
            SPI_SCLK = 1'b0;
        end
        if (nbits == 8) obs_miso.push_back(got);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"}, SPI_MISO, 0);
        chk({tag, "_tx_ack"}, tx_ack, 0);
        chk({tag, "_tx_full"}, tx_full, 0);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_tx_underrun"}, tx_underrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_n(3);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        nrst = 1'b1;
        wait_n(10);

        // single byte
        tx_put(8'hA5);
        chk("t1_full_before", tx_full, 1);
        exp_rx.push_back(8'h55);
        exp_miso.push_back(8'hA5);
        u0 = under_cnt;
        cs_low();
        chk("t1_busy", busy, 1);
        xfer(8'h55, 8, 1'b1);
        wait_n(16);
        chk("t1_full_after", tx_full, 0);
        chk("t1_underruns", under_cnt - u0, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_miso_idle", SPI_MISO, 0);

        // back-to-back with refill while the register is still full
        tx_put(8'hF0);
        exp_rx.push_back(8'h01); exp_rx.push_back(8'h02); exp_rx.push_back(8'h03);
        exp_miso.push_back(8'hF0); exp_miso.push_back(8'hF1); exp_miso.push_back(8'hF2);
        u0 = under_cnt;
        fork
            begin
                cs_low();
                xfer(8'h01, 8, 1'b0);
                xfer(8'h02, 8, 1'b0);
                xfer(8'h03, 8, 1'b1);
                wait_n(16);
            end
            begin
                tx_put(8'hF1);
                tx_put(8'hF2);
            end
        join
        chk("t2_underruns", under_cnt - u0, 0);
        chk("t2_full_after", tx_full, 0);

        // underrun
        exp_rx.push_back(8'h5A);
        exp_miso.push_back(8'h00);
        u0 = under_cnt;
        cs_low();
        xfer(8'h5A, 8, 1'b1);
        wait_n(16);
        chk("t3_underruns", under_cnt - u0, 1);
        chk("t3_rx_data", rx_data, 8'h5A);

        // abort after five bits, then a clean frame
        u0 = under_cnt;
        cs_low();
        xfer(8'hFF, 5, 1'b1);
        wait_n(16);
        chk("t4_rx_held", rx_data, 8'h5A);
        chk("t4_underruns", under_cnt - u0, 1);
        exp_rx.push_back(8'hC3);
        exp_miso.push_back(8'h00);
        cs_low();
        xfer(8'hC3, 8, 1'b1);
        wait_n(16);
        chk("t4_rx_next", rx_data, 8'hC3);

        // reset mid-byte; CS still low at release must not start a frame
        tx_put(8'h77);
        cs_low();
        xfer(8'hAA, 4, 1'b0);
        nrst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        wait_n(3);
        nrst = 1'b1;
        u0 = under_cnt;
        wait_n(20);
        chk("t5_busy_cs_low", busy, 1);
        chk("t5_no_frame", under_cnt - u0, 0);
        chk("t5_miso", SPI_MISO, 0);
        SPI_CS = 1'b1;
        wait_n(16);
        exp_rx.push_back(8'h3C);
        exp_miso.push_back(8'h00);
        u0 = under_cnt;
        cs_low();
        xfer(8'h3C, 8, 1'b1);
        wait_n(16);
        chk("t5_underruns", under_cnt - u0, 1);
        chk("t5_rx_data", rx_data, 8'h3C);

        wait_n(10);
        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("miso_queue_drained", exp_miso.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
